dataflow_fork_buffered: RTL

- N-way stream broadcaster with one input and NUM_OUTPUTS outputs.
- Each branch has its own FIFO, so consumers (level meter, S/PDIF transmitter, future taps) can accept each sample on different cycles instead of all in the same cycle.
- Adds a per-branch enable mask, a blocking or dropping full policy, and sticky per-branch drop flags.
- Sits between serial_audio_decoder and its consumers in the sclk domain. The payload carries { is_left, audio }.

---
 rtl/dataflow_fork_buffered.sv | 84 ++++++++
 1 files changed

// File: rtl/dataflow_fork_buffered.sv
// N-way stream broadcaster: one input fans out to NUM_OUTPUTS branches, each with its own FIFO,
// a per-branch enable/flush, and either a stall-on-full or a drop-on-full policy with sticky drop flags.
module dataflow_fork_buffered #(
  parameter int NUM_OUTPUTS = 2,
  parameter int DATA_WIDTH  = 33,
  parameter int DEPTH       = 4,
  parameter int BLOCKING    = 1
) (
  input  logic                              clk,
  input  logic                              nreset,
  input  logic [NUM_OUTPUTS-1:0]            i_enable,
  input  logic                              i_valid,
  output logic                              i_ready,
  input  logic [DATA_WIDTH-1:0]             i_data,
  output logic [NUM_OUTPUTS-1:0]            o_valid,
  input  logic [NUM_OUTPUTS-1:0]            o_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] o_data,
  output logic [NUM_OUTPUTS-1:0]            o_dropped,
  input  logic                              i_clear_dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [NUM_OUTPUTS-1:0] full;
  logic [NUM_OUTPUTS-1:0] push;
  logic [NUM_OUTPUTS-1:0] pop;
  logic [NUM_OUTPUTS-1:0] drop_set;
  logic                   accept;

  // Stall decision looks only at registered fullness, so o_ready never reaches i_ready.
  assign i_ready  = nreset & ((BLOCKING != 0) ? ~|(i_enable & full) : 1'b1);
  assign accept   = i_valid & i_ready;
  assign push     = {NUM_OUTPUTS{accept}} & i_enable & ~full;
  assign pop      = o_valid & o_ready;
  assign drop_set = (BLOCKING != 0) ? '0 : ({NUM_OUTPUTS{accept}} & i_enable & full);

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_branch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    assign full[k]    = (count == FULL_COUNT);
    assign o_valid[k] = (count != '0);
    assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = o_valid[k] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
      if (push[k]) mem[wr_ptr] <= i_data;
    end

    // Disabling a branch flushes it; any pop seen on that edge is simply absorbed by the flush.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (!i_enable[k]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[k])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // A new drop on the same edge as a clear request must survive.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      o_dropped <= '0;
    end else begin
      o_dropped <= (o_dropped & ~{NUM_OUTPUTS{i_clear_dropped}}) | drop_set;
    end
  end

endmodule
